// File: rtl/sreg_pkg.sv
// Shared definitions for the SIPO/PISO shift-register family:
// default word width and the two-state shifter FSM encoding.
package sreg_pkg;

   localparam int unsigned SREG_WIDTH = 4;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SHIFT = 1'b1;

endpackage

// File: rtl/piso_sreg.sv
// Parallel-in, serial-out shift register with a one-word holding buffer so
// back-to-back words leave the serial line with no idle gap.
module piso_sreg
   import sreg_pkg::*;
#(
   parameter int unsigned WIDTH     = SREG_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pinp,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             frame_last,
   output logic             busy
);

   localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             in_reset_q;

   logic accept;
   logic last_bit;
   logic xfer;

   always_comb begin
      accept   = load_valid && load_ready;
      last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
      xfer     = hold_full_q && ((state_q == ST_IDLE) || last_bit);

      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;

      // accept needs an empty hold and xfer a full one, so they never collide
      if (accept) begin
         hold_d      = pinp;
         hold_full_d = 1'b1;
      end

      if (xfer) begin
         shreg_d     = hold_q;
         hold_full_d = 1'b0;
         cnt_d       = '0;
         state_d     = ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
         if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
         end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
         end
         if (last_bit) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shreg_q     <= '0;
         cnt_q       <= '0;
         in_reset_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         in_reset_q  <= 1'b0;
      end
   end

   // in_reset_q keeps load_ready low while reset is held, without a comb path
   assign load_ready  = !hold_full_q && !in_reset_q;
   assign sout_valid  = (state_q == ST_SHIFT);
   assign sout        = sout_valid && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
   assign frame_start = sout_valid && (cnt_q == '0);
   assign frame_last  = sout_valid && (cnt_q == CNT_LAST);
   assign busy        = sout_valid || hold_full_q;

endmodule
